ahb_master_arbiter: RTL and testbench

AHB_MASTER_ARBITER -- requirements
Module: ahb_master_arbiter

---
 rtl/ahb_master_arbiter.sv | 160 ++++++++++++++++
 tb/tb_ahb_master_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_master_arbiter.sv
// ---------------------------------------------------------------------------
// ahb_master_arbiter
//
// Purpose:
//   Two-master AHB-Lite arbiter. Master 0 is the core AHB bridge and master 1
//   is a secondary master (DMA/debug). One master owns the address phase at a
//   time. The data phase is tracked separately so the old owner can finish its
//   data phase while the new owner drives its first address.
//
// Parameters:
//   AWIDTH  address width (default 32)
//   DWIDTH  data width    (default 32)
//
// Ports:
//   HCLK, HRESETn                 clock (rising edge) / async active-low reset
//   Mx_HADDR/HTRANS/HWRITE/HSIZE  master address-phase inputs (x = 0, 1)
//   Mx_HWDATA                     master write data (data phase)
//   Mx_HRDATA                     read data, broadcast to both masters
//   Mx_HREADY, Mx_HRESP           per-master ready / response
//   HADDR/HTRANS/HWRITE/HSIZE     muxed address phase to the interconnect
//   HWDATA                        write data muxed by data-phase owner
//   HRDATA, HREADY, HRESP         slave-side response from the interconnect
//   GNT                           one-hot address-phase owner
//
// Configuration:
//   ARB_PARK_M0_EN  defined   : an idle M1 owner hands the grant back to M0
//                   undefined : the grant parks on the last owner
// ---------------------------------------------------------------------------
module ahb_master_arbiter #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
) (
  input  logic              HCLK,
  input  logic              HRESETn,

  input  logic [AWIDTH-1:0] M0_HADDR,
  input  logic [1:0]        M0_HTRANS,
  input  logic              M0_HWRITE,
  input  logic [2:0]        M0_HSIZE,
  input  logic [DWIDTH-1:0] M0_HWDATA,
  output logic [DWIDTH-1:0] M0_HRDATA,
  output logic              M0_HREADY,
  output logic              M0_HRESP,

  input  logic [AWIDTH-1:0] M1_HADDR,
  input  logic [1:0]        M1_HTRANS,
  input  logic              M1_HWRITE,
  input  logic [2:0]        M1_HSIZE,
  input  logic [DWIDTH-1:0] M1_HWDATA,
  output logic [DWIDTH-1:0] M1_HRDATA,
  output logic              M1_HREADY,
  output logic              M1_HRESP,

  output logic [AWIDTH-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [DWIDTH-1:0] HWDATA,
  input  logic [DWIDTH-1:0] HRDATA,
  input  logic              HREADY,
  input  logic              HRESP,

  output logic [1:0]        GNT
);

  typedef enum logic {
    GNT_M0 = 1'b0,
    GNT_M1 = 1'b1
  } state_e;

  state_e state_q, state_d;
  logic   dp_valid_q, dp_valid_d;
  logic   dp_owner_q, dp_owner_d;

  logic m0_req;
  logic m1_req;
  logic gnt_m1;
  logic own_req;
  logic oth_req;

  assign m0_req  = M0_HTRANS[1];
  assign m1_req  = M1_HTRANS[1];
  assign gnt_m1  = (state_q == GNT_M1);
  assign own_req = gnt_m1 ? m1_req : m0_req;
  assign oth_req = gnt_m1 ? m0_req : m1_req;

  // Grant and data-phase tracking only advance when the slave accepts the
  // current beat; HREADY low freezes everything, including during an error.
  always_comb begin
    state_d    = state_q;
    dp_valid_d = dp_valid_q;
    dp_owner_d = dp_owner_q;
    if (HREADY) begin
      dp_valid_d = own_req;
      dp_owner_d = gnt_m1;
      // Handover only when the owner is idle, so back-to-back bursts are
      // never preempted.
      if (!own_req && oth_req) begin
        state_d = gnt_m1 ? GNT_M0 : GNT_M1;
      end
`ifdef ARB_PARK_M0_EN
      else if (gnt_m1 && !m1_req && !m0_req) begin
        state_d = GNT_M0;
      end
`endif
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q    <= GNT_M0;
      dp_valid_q <= 1'b0;
      dp_owner_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      dp_valid_q <= dp_valid_d;
      dp_owner_q <= dp_owner_d;
    end
  end

  // Address phase follows the grant, write data follows the data-phase owner.
  assign HADDR  = gnt_m1 ? M1_HADDR  : M0_HADDR;
  assign HTRANS = gnt_m1 ? M1_HTRANS : M0_HTRANS;
  assign HWRITE = gnt_m1 ? M1_HWRITE : M0_HWRITE;
  assign HSIZE  = gnt_m1 ? M1_HSIZE  : M0_HSIZE;
  assign HWDATA = dp_owner_q ? M1_HWDATA : M0_HWDATA;
  assign GNT    = gnt_m1 ? 2'b10 : 2'b01;

  assign M0_HRDATA = HRDATA;
  assign M1_HRDATA = HRDATA;

  assign M0_HRESP = dp_valid_q && !dp_owner_q && HRESP;
  assign M1_HRESP = dp_valid_q &&  dp_owner_q && HRESP;

  // A master sees the slave's HREADY while it owns the data phase or the
  // address phase; a non-owner that is requesting is held off, and an idle
  // non-owner sees a ready bus.
  always_comb begin
    M0_HREADY = 1'b1;
    if (dp_valid_q && !dp_owner_q) begin
      M0_HREADY = HREADY;
    end else if (!gnt_m1) begin
      M0_HREADY = HREADY;
    end else if (m0_req) begin
      M0_HREADY = 1'b0;
    end
  end

  always_comb begin
    M1_HREADY = 1'b1;
    if (dp_valid_q && dp_owner_q) begin
      M1_HREADY = HREADY;
    end else if (gnt_m1) begin
      M1_HREADY = HREADY;
    end else if (m1_req) begin
      M1_HREADY = 1'b0;
    end
  end

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ahb_master_arbiter
//
// Directed bench for ahb_master_arbiter. Each scenario task drives one
// situation cycle by cycle and compares outputs with hand-computed values.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 time
// unit later, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_ahb_master_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [1:0] SEQ    = 2'b11;

  logic          HCLK;
  logic          HRESETn;
  logic [AW-1:0] M0_HADDR, M1_HADDR, HADDR;
  logic [1:0]    M0_HTRANS, M1_HTRANS, HTRANS;
  logic          M0_HWRITE, M1_HWRITE, HWRITE;
  logic [2:0]    M0_HSIZE, M1_HSIZE, HSIZE;
  logic [DW-1:0] M0_HWDATA, M1_HWDATA, HWDATA;
  logic [DW-1:0] M0_HRDATA, M1_HRDATA, HRDATA;
  logic          M0_HREADY, M1_HREADY, HREADY;
  logic          M0_HRESP, M1_HRESP, HRESP;
  logic [1:0]    GNT;

  int checks = 0;
  int errors = 0;

  ahb_master_arbiter #(.AWIDTH(AW), .DWIDTH(DW)) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .M0_HADDR  (M0_HADDR),
    .M0_HTRANS (M0_HTRANS),
    .M0_HWRITE (M0_HWRITE),
    .M0_HSIZE  (M0_HSIZE),
    .M0_HWDATA (M0_HWDATA),
    .M0_HRDATA (M0_HRDATA),
    .M0_HREADY (M0_HREADY),
    .M0_HRESP  (M0_HRESP),
    .M1_HADDR  (M1_HADDR),
    .M1_HTRANS (M1_HTRANS),
    .M1_HWRITE (M1_HWRITE),
    .M1_HSIZE  (M1_HSIZE),
    .M1_HWDATA (M1_HWDATA),
    .M1_HRDATA (M1_HRDATA),
    .M1_HREADY (M1_HREADY),
    .M1_HRESP  (M1_HRESP),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HSIZE     (HSIZE),
    .HWDATA    (HWDATA),
    .HRDATA    (HRDATA),
    .HREADY    (HREADY),
    .HRESP     (HRESP),
    .GNT       (GNT)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic idle_inputs();
    M0_HADDR  = '0; M0_HTRANS = IDLE; M0_HWRITE = 1'b0; M0_HSIZE = 3'b010;
    M0_HWDATA = '0;
    M1_HADDR  = '0; M1_HTRANS = IDLE; M1_HWRITE = 1'b0; M1_HSIZE = 3'b010;
    M1_HWDATA = '0;
    HRDATA = '0; HREADY = 1'b1; HRESP = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    HRESETn = 1'b0;
    step();
    step();
    HRESETn = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    HRESETn = 1'b0;
    M0_HTRANS = NONSEQ; M1_HTRANS = NONSEQ; HRESP = 1'b1;
    #1;
    checks++; if (GNT !== 2'b01) begin errors++; $display("[TB] FAIL rst_gnt got %b exp 01", GNT); end
    checks++; if (HTRANS !== NONSEQ) begin errors++; $display("[TB] FAIL rst_htrans got %b exp 10", HTRANS); end
    checks++; if (M0_HRESP !== 1'b0 || M1_HRESP !== 1'b0) begin errors++; $display("[TB] FAIL rst_hresp got %b%b exp 00", M0_HRESP, M1_HRESP); end
    checks++; if (M1_HREADY !== 1'b0) begin errors++; $display("[TB] FAIL rst_m1_hready_req got %b exp 0", M1_HREADY); end
    checks++; if (M0_HREADY !== 1'b1) begin errors++; $display("[TB] FAIL rst_m0_hready got %b exp 1", M0_HREADY); end
    M1_HTRANS = IDLE; HREADY = 1'b0;
    #1;
    checks++; if (M1_HREADY !== 1'b1) begin errors++; $display("[TB] FAIL rst_m1_hready_idle got %b exp 1", M1_HREADY); end
    checks++; if (M0_HREADY !== 1'b0) begin errors++; $display("[TB] FAIL rst_m0_hready_follow got %b exp 0", M0_HREADY); end
    step();
    HRESETn = 1'b1;
  endtask

  task automatic test_m0_read();
    do_reset();
    M0_HTRANS = NONSEQ; M0_HADDR = 32'h1000_0004; M0_HWRITE = 1'b0;
    #1;
    checks++; if (HADDR !== 32'h1000_0004) begin errors++; $display("[TB] FAIL rd_haddr got %h exp 10000004", HADDR); end
    checks++; if (HTRANS !== NONSEQ || HWRITE !== 1'b0 || HSIZE !== 3'b010) begin errors++; $display("[TB] FAIL rd_ctrl got %b %b %b exp 10 0 010", HTRANS, HWRITE, HSIZE); end
    checks++; if (M0_HREADY !== 1'b1) begin errors++; $display("[TB] FAIL rd_m0_hready_addr got %b exp 1", M0_HREADY); end
    checks++; if (GNT !== 2'b01) begin errors++; $display("[TB] FAIL rd_gnt_addr got %b exp 01", GNT); end
    step();
    M0_HTRANS = IDLE; HRDATA = 32'hDEAD_BEEF;
    #1;
    checks++; if (M0_HRDATA !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL rd_m0_hrdata got %h exp deadbeef", M0_HRDATA); end
    checks++; if (M1_HRDATA !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL rd_m1_hrdata got %h exp deadbeef", M1_HRDATA); end
    checks++; if (GNT !== 2'b01) begin errors++; $display("[TB] FAIL rd_gnt_data got %b exp 01", GNT); end
    checks++; if (M0_HREADY !== 1'b1) begin errors++; $display("[TB] FAIL rd_m0_hready_data got %b exp 1", M0_HREADY); end
  endtask

  task automatic test_m1_write_park();
    logic [1:0] park_gnt;
`ifdef ARB_PARK_M0_EN
    park_gnt = 2'b01;
`else
    park_gnt = 2'b10;
`endif
    do_reset();
    M1_HTRANS = NONSEQ; M1_HADDR = 32'h8001_0000; M1_HWRITE = 1'b1;
    #1;
    checks++; if (M1_HREADY !== 1'b0) begin errors++; $display("[TB] FAIL wr_m1_stall got %b exp 0", M1_HREADY); end
    checks++; if (GNT !== 2'b01 || HTRANS !== IDLE) begin errors++; $display("[TB] FAIL wr_pre_gnt got %b %b exp 01 00", GNT, HTRANS); end
    step();
    #1;
    checks++; if (GNT !== 2'b10) begin errors++; $display("[TB] FAIL wr_gnt got %b exp 10", GNT); end
    checks++; if (HADDR !== 32'h8001_0000 || HTRANS !== NONSEQ || HWRITE !== 1'b1) begin errors++; $display("[TB] FAIL wr_addr got %h %b %b exp 80010000 10 1", HADDR, HTRANS, HWRITE); end
    checks++; if (M1_HREADY !== 1'b1) begin errors++; $display("[TB] FAIL wr_m1_hready got %b exp 1", M1_HREADY); end
    step();
    M1_HTRANS = IDLE; M1_HWDATA = 32'h0000_00A5; M0_HWDATA = 32'h1234_5678;
    #1;
    checks++; if (HWDATA !== 32'h0000_00A5) begin errors++; $display("[TB] FAIL wr_hwdata got %h exp 000000a5", HWDATA); end
    checks++; if (GNT !== 2'b10) begin errors++; $display("[TB] FAIL wr_gnt_data got %b exp 10", GNT); end
    step();
    #1;
    checks++; if (GNT !== park_gnt) begin errors++; $display("[TB] FAIL park_gnt got %b exp %b", GNT, park_gnt); end
    checks++; if (HWDATA !== 32'h0000_00A5) begin errors++; $display("[TB] FAIL park_hwdata got %h exp 000000a5", HWDATA); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    M1_HTRANS = NONSEQ; M1_HADDR = 32'h2000_0000;
    for (int i = 0; i < 4; i++) begin
      M0_HTRANS = (i == 0) ? NONSEQ : SEQ;
      M0_HADDR  = 32'h0000_0100 + 32'(i * 4);
      #1;
      checks++; if (M1_HREADY !== 1'b0) begin errors++; $display("[TB] FAIL b2b_m1_stall[%0d] got %b exp 0", i, M1_HREADY); end
      checks++; if (GNT !== 2'b01 || HADDR !== 32'h0000_0100 + 32'(i * 4)) begin errors++; $display("[TB] FAIL b2b_m0_own[%0d] got %b %h", i, GNT, HADDR); end
      step();
    end
    M0_HTRANS = IDLE;
    #1;
    checks++; if (GNT !== 2'b01 || M1_HREADY !== 1'b0 || M0_HREADY !== 1'b1) begin errors++; $display("[TB] FAIL b2b_last_data got %b %b %b exp 01 0 1", GNT, M1_HREADY, M0_HREADY); end
    step();
    #1;
    checks++; if (GNT !== 2'b10 || HTRANS !== NONSEQ || HADDR !== 32'h2000_0000) begin errors++; $display("[TB] FAIL b2b_switch got %b %b %h exp 10 10 20000000", GNT, HTRANS, HADDR); end
    checks++; if (M1_HREADY !== 1'b1) begin errors++; $display("[TB] FAIL b2b_m1_go got %b exp 1", M1_HREADY); end
  endtask

  task automatic test_wait_states();
    do_reset();
    M1_HTRANS = NONSEQ; M1_HADDR = 32'h3000_0000;
    step();
    #1;
    checks++; if (GNT !== 2'b10) begin errors++; $display("[TB] FAIL ws_gnt_addr got %b exp 10", GNT); end
    step();
    M1_HTRANS = IDLE; M0_HTRANS = NONSEQ; M0_HADDR = 32'h0000_0040; HREADY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (M1_HREADY !== 1'b0 || M0_HREADY !== 1'b0) begin errors++; $display("[TB] FAIL ws_hready[%0d] got m1 %b m0 %b exp 0 0", i, M1_HREADY, M0_HREADY); end
      checks++; if (GNT !== 2'b10) begin errors++; $display("[TB] FAIL ws_gnt[%0d] got %b exp 10", i, GNT); end
      step();
    end
    HREADY = 1'b1; HRDATA = 32'hCAFE_0001;
    #1;
    checks++; if (M1_HREADY !== 1'b1 || M1_HRDATA !== 32'hCAFE_0001 || GNT !== 2'b10) begin errors++; $display("[TB] FAIL ws_done got %b %h %b", M1_HREADY, M1_HRDATA, GNT); end
    step();
    #1;
    checks++; if (GNT !== 2'b01 || HADDR !== 32'h0000_0040) begin errors++; $display("[TB] FAIL ws_handover got %b %h exp 01 00000040", GNT, HADDR); end
  endtask

  task automatic test_error();
    do_reset();
    M0_HTRANS = NONSEQ; M0_HWRITE = 1'b1; M0_HADDR = 32'h0000_0080;
    M1_HTRANS = NONSEQ;
    step();
    M0_HTRANS = IDLE; HREADY = 1'b0; HRESP = 1'b1;
    #1;
    checks++; if (M0_HRESP !== 1'b1 || M1_HRESP !== 1'b0) begin errors++; $display("[TB] FAIL err1_hresp got %b %b exp 1 0", M0_HRESP, M1_HRESP); end
    checks++; if (M0_HREADY !== 1'b0 || GNT !== 2'b01) begin errors++; $display("[TB] FAIL err1_state got %b %b exp 0 01", M0_HREADY, GNT); end
    step();
    HREADY = 1'b1;
    #1;
    checks++; if (M0_HRESP !== 1'b1 || M1_HRESP !== 1'b0) begin errors++; $display("[TB] FAIL err2_hresp got %b %b exp 1 0", M0_HRESP, M1_HRESP); end
    checks++; if (M0_HREADY !== 1'b1 || GNT !== 2'b01) begin errors++; $display("[TB] FAIL err2_state got %b %b exp 1 01", M0_HREADY, GNT); end
    step();
    HRESP = 1'b0;
    #1;
    checks++; if (GNT !== 2'b10) begin errors++; $display("[TB] FAIL err_after_gnt got %b exp 10", GNT); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    M1_HTRANS = NONSEQ; M1_HADDR = 32'h4000_0000;
    step();
    step();
    M1_HTRANS = IDLE; M0_HTRANS = NONSEQ; HREADY = 1'b0; HRESP = 1'b1;
    #1;
    checks++; if (M1_HRESP !== 1'b1 || GNT !== 2'b10) begin errors++; $display("[TB] FAIL mid_pre got %b %b exp 1 10", M1_HRESP, GNT); end
    HRESETn = 1'b0;
    #1;
    checks++; if (GNT !== 2'b01 || HTRANS !== NONSEQ) begin errors++; $display("[TB] FAIL mid_gnt got %b %b exp 01 10", GNT, HTRANS); end
    checks++; if (M1_HRESP !== 1'b0 || M0_HRESP !== 1'b0) begin errors++; $display("[TB] FAIL mid_dp_valid got %b %b exp 0 0", M1_HRESP, M0_HRESP); end
    step();
    HRESETn = 1'b1; HRESP = 1'b0; HREADY = 1'b1; M0_HTRANS = IDLE;
    #1;
    checks++; if (GNT !== 2'b01 || M1_HREADY !== 1'b1) begin errors++; $display("[TB] FAIL mid_after got %b %b exp 01 1", GNT, M1_HREADY); end
  endtask

  initial begin
    idle_inputs();
    HRESETn = 1'b0;
    test_reset();
    test_m0_read();
    test_m1_write_park();
    test_back_to_back();
    test_wait_states();
    test_error();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout reached");
    $fatal(1, "timeout");
  end

endmodule
